// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: encodes one-hot ALU op requests into the 3-bit sel,
// queues them in a small circular FIFO and sequences them through the
// external combinational ALU (issue, settle, capture). Results are written
// back into a 4x4-bit register file and shown on 'result'.
module alu_op_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [7:0] op_onehot,
    input  logic [1:0] src_a,
    input  logic [1:0] src_b,
    input  logic [1:0] dst,
    input  logic       load_en,
    input  logic [1:0] load_addr,
    input  logic [3:0] load_data,
    output logic [3:0] exe_rs,
    output logic [3:0] exe_rt,
    output logic [2:0] exe_sel,
    input  logic [3:0] exe_rd,
    output logic [3:0] result,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0] sel;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] dst;
    } entry_t;

    state_e      state_q, state_d;
    entry_t      fifo_mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]  regs_q [4];
    logic [3:0]  exe_rs_q, exe_rt_q, result_q;
    logic [2:0]  exe_sel_q;
    logic [1:0]  dst_q;
    logic        done_q, err_q, busy_q, busy_d;

    logic [2:0]  enc_sel;
    logic [3:0]  bit_cnt;
    logic        enc_valid;
    logic        fifo_empty, fifo_full;
    logic        accept, push, bad_req;
    logic        load_ok, load_bad;
    logic        pop, capture;
    entry_t      head, new_entry;

    assign exe_rs  = exe_rs_q;
    assign exe_rt  = exe_rt_q;
    assign exe_sel = exe_sel_q;
    assign result  = result_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

    // One-hot to binary encoder; anything other than exactly one set bit is invalid.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        enc_sel = '0;
        bit_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            if (op_onehot[i]) begin
                enc_sel = 3'(i);
                bit_cnt = bit_cnt + 4'd1;
            end
        end
        enc_valid = (bit_cnt == 4'd1);
    end

    // FIFO status: the extra pointer bit separates full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A direct load blocks request acceptance for the cycle.
    assign op_ready  = !fifo_full && !load_en;
    assign accept    = op_valid && op_ready;
    assign push      = accept && enc_valid;
    assign bad_req   = accept && !enc_valid;
    assign load_ok   = load_en && fifo_empty && (state_q == S_IDLE);
    assign load_bad  = load_en && !load_ok;

    assign head      = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign new_entry = '{sel: enc_sel, src_a: src_a, src_b: src_b, dst: dst};

    assign wr_ptr_d  = wr_ptr_q + (AW+1)'(push);
    assign rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);

    // FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone define which entries are valid.
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= new_entry;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next state: pop, one settle cycle, then capture.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (!fifo_empty) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Sequencer outputs: pop strobe in IDLE, write-back strobe in CAPTURE.
    always_comb begin
        pop     = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE:    pop = !fifo_empty;
            S_CAPTURE: capture = 1'b1;
            default:   ;
        endcase
    end

    // busy reflects the state being entered, so the registered flag is exact.
    assign busy_d = (wr_ptr_d != rd_ptr_d) || (state_d != S_IDLE);

    // Datapath: operand issue, register file, write-back and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            exe_rs_q  <= '0;
            exe_rt_q  <= '0;
            exe_sel_q <= '0;
            dst_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= capture;
            err_q  <= bad_req || load_bad;
            busy_q <= busy_d;

            if (pop) begin
                exe_rs_q  <= regs_q[head.src_a];
                exe_rt_q  <= regs_q[head.src_b];
                exe_sel_q <= head.sel;
                dst_q     <= head.dst;
            end

            // A load is only honoured in IDLE, so it never collides with capture.
            if (load_ok) begin
                regs_q[load_addr] <= load_data;
            end else if (capture) begin
                regs_q[dst_q] <= exe_rd;
            end

            if (capture) begin
                result_q <= exe_rd;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer. The bench also plays the role of
// the combinational ALU. A transaction-level model (request queue, register
// array and a scheduled write-back time) predicts every output each cycle.
module tb_alu_op_sequencer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] op_onehot;
    logic [1:0] src_a, src_b, dst;
    logic       load_en;
    logic [1:0] load_addr;
    logic [3:0] load_data;
    logic [3:0] exe_rs, exe_rt, exe_rd, result;
    logic [2:0] exe_sel;
    logic       busy, done, err;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_onehot (op_onehot),
        .src_a     (src_a),
        .src_b     (src_b),
        .dst       (dst),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .exe_rs    (exe_rs),
        .exe_rt    (exe_rt),
        .exe_sel   (exe_sel),
        .exe_rd    (exe_rd),
        .result    (result),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Reference ALU behaviour.
    function automatic logic [3:0] alu(input logic [2:0] s, input logic [3:0] rs, input logic [3:0] rt);
        case (s)
            3'd0:    return rs - rt;
            3'd1:    return rs + rt;
            3'd2:    return rs | rt;
            3'd3:    return rs & rt;
            3'd4:    return {rt[3], rt[3:1]};
            3'd5:    return {rs[2:0], rs[3]};
            3'd6:    return {3'b0, rs < rt};
            default: return {3'b0, rs == rt};
        endcase
    endfunction

    assign exe_rd = alu(exe_sel, exe_rs, exe_rt);

    // ---------------- model state ----------------
    typedef struct {
        logic [2:0] sel;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] d;
    } req_t;

    req_t       q[$];
    logic [3:0] m_regs [4];
    bit         m_known = 0;
    bit         m_inflight;
    int         m_wb_t;
    logic [3:0] m_rd, m_rs, m_rt, m_result;
    logic [2:0] m_sel;
    logic [1:0] m_dst;
    bit         m_done, m_err, m_busy;
    int         t = 0;
    bit         last_acc;
    logic       last_ready_dut;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, t);
        end
    endtask

    function automatic bit onehot_ok(input logic [7:0] oh);
        return (oh != 8'd0) && ((oh & (oh - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
        logic [2:0] r = 3'd0;
        for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
        return r;
    endfunction

    // One clock cycle: drive inputs, check op_ready, advance the model, clock, compare.
    task automatic tick(input logic v, input logic [7:0] oh, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] d, input logic le, input logic [1:0] la,
                        input logic [3:0] ld, input logic r);
        req_t e;
        bit   rdy, acc, lok;
        op_valid  = v;
        op_onehot = oh;
        src_a     = a;
        src_b     = b;
        dst       = d;
        load_en   = le;
        load_addr = la;
        load_data = ld;
        rst       = r;
        #1;
        rdy = (q.size() < DEPTH) && !le;
        last_ready_dut = op_ready;
        if (m_known) check("op_ready", 32'(op_ready), 32'(rdy));
        if (r) begin
            q.delete();
            for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
            m_inflight = 0;
            m_rs = 4'd0; m_rt = 4'd0; m_sel = 3'd0; m_result = 4'd0;
            m_done = 0; m_err = 0; m_busy = 0;
            m_known = 1;
            last_acc = 0;
        end else begin
            acc = v && rdy;
            lok = le && (q.size() == 0) && !m_inflight;
            m_err  = (acc && !onehot_ok(oh)) || (le && !lok);
            m_done = 0;
            if (m_inflight && m_wb_t == t) begin
                m_regs[m_dst] = m_rd;
                m_result      = m_rd;
                m_done        = 1;
                m_inflight    = 0;
            end else if (!m_inflight && q.size() > 0) begin
                e = q.pop_front();
                m_rs  = m_regs[e.a];
                m_rt  = m_regs[e.b];
                m_sel = e.sel;
                m_dst = e.d;
                m_rd  = alu(e.sel, m_rs, m_rt);
                m_inflight = 1;
                m_wb_t     = t + 2;
            end
            if (lok) m_regs[la] = ld;
            if (acc && onehot_ok(oh)) q.push_back('{onehot_idx(oh), a, b, d});
            m_busy   = (q.size() > 0) || m_inflight;
            last_acc = acc;
        end
        t++;
        @(posedge clk);
        @(negedge clk);
        check("exe_rs",  32'(exe_rs),  32'(m_rs));
        check("exe_rt",  32'(exe_rt),  32'(m_rt));
        check("exe_sel", 32'(exe_sel), 32'(m_sel));
        check("result",  32'(result),  32'(m_result));
        check("busy",    32'(busy),    32'(m_busy));
        check("done",    32'(done),    32'(m_done));
        check("err",     32'(err),     32'(m_err));
    endtask

    task automatic idle();
        tick(1'b0, 8'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0);
    endtask

    task automatic reset_cycle();
        tick(1'b0, 8'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b1);
    endtask

    task automatic op(input logic [7:0] oh, input logic [1:0] a, input logic [1:0] b, input logic [1:0] d);
        tick(1'b1, oh, a, b, d, 1'b0, 2'd0, 4'd0, 1'b0);
    endtask

    task automatic load(input logic [1:0] la, input logic [3:0] ld);
        tick(1'b0, 8'd0, 2'd0, 2'd0, 2'd0, 1'b1, la, ld, 1'b0);
    endtask

    // Idle until the model reports nothing outstanding, with a cycle budget.
    task automatic drain(input string name);
        int guard = 0;
        while (m_busy && guard < 100) begin
            idle();
            guard++;
        end
        check(name, 32'(busy), 32'(0));
    endtask

    initial begin
        int          sent, guard;
        int          dones[$];
        bit          saw_full;
        logic [7:0]  boh;
        logic [1:0]  ba, bb, bd;
        logic [7:0]  roh;
        int          sel_k;

        op_valid = 0; op_onehot = 0; src_a = 0; src_b = 0; dst = 0;
        load_en = 0; load_addr = 0; load_data = 0; rst = 1;

        // Reset state.
        reset_cycle();
        reset_cycle();
        check("reset_result", 32'(result), 32'(0));
        check("reset_busy",   32'(busy),   32'(0));
        check("reset_exe_rs", 32'(exe_rs), 32'(0));

        // SUB r2 = r0 - r1 with r0=5, r1=3.
        load(2'd0, 4'd5);
        load(2'd1, 4'd3);
        op(8'b0000_0001, 2'd0, 2'd1, 2'd2);
        idle();
        check("sub_exe_sel", 32'(exe_sel), 32'(0));
        check("sub_exe_rs",  32'(exe_rs),  32'(5));
        check("sub_exe_rt",  32'(exe_rt),  32'(3));
        idle();
        check("sub_no_early_done", 32'(done), 32'(0));
        idle();
        check("sub_done",   32'(done),   32'(1));
        check("sub_result", 32'(result), 32'(2));

        // Dependent chain: ADD r3 = r2 + r1, then LT r0 = r3 < r0.
        op(8'b0000_0010, 2'd2, 2'd1, 2'd3);
        op(8'b0100_0000, 2'd3, 2'd0, 2'd0);
        idle();
        idle();
        check("add_done",   32'(done),   32'(1));
        check("add_result", 32'(result), 32'(5));
        idle();
        idle();
        idle();
        check("lt_done",   32'(done),   32'(1));
        check("lt_result", 32'(result), 32'(0));
        idle();

        // Invalid encodings: error pulse, nothing queued.
        op(8'b0000_0000, 2'd0, 2'd0, 2'd1);
        check("inv_zero_err",  32'(err),  32'(1));
        check("inv_zero_busy", 32'(busy), 32'(0));
        op(8'b0001_0100, 2'd0, 2'd0, 2'd1);
        check("inv_multi_err",  32'(err),  32'(1));
        check("inv_multi_busy", 32'(busy), 32'(0));
        idle();
        check("inv_err_clears", 32'(err), 32'(0));

        // Load while an op is in flight is dropped.
        op(8'b0000_0100, 2'd0, 2'd1, 2'd1);
        load(2'd2, 4'd7);
        check("load_busy_err", 32'(err), 32'(1));
        drain("drain_or");
        // Load together with a request while idle: load wins, request not taken.
        tick(1'b1, 8'b0000_0010, 2'd0, 2'd0, 2'd3, 1'b1, 2'd2, 4'd7, 1'b0);
        check("load_pri_ready", 32'(last_ready_dut), 32'(0));
        check("load_pri_busy",  32'(busy), 32'(0));
        check("load_pri_err",   32'(err),  32'(0));
        op(8'b0000_0010, 2'd2, 2'd2, 2'd3);
        idle();
        idle();
        idle();
        check("load_pri_value", 32'(result), 32'(14));

        // Reset during CAPTURE of ADD r2.
        op(8'b0000_0010, 2'd3, 2'd3, 2'd2);
        idle();
        idle();
        reset_cycle();
        check("rst_mid_result", 32'(result), 32'(0));
        check("rst_mid_done",   32'(done),   32'(0));
        check("rst_mid_busy",   32'(busy),   32'(0));
        idle();
        check("rst_mid_no_late_done", 32'(done), 32'(0));

        // Burst of back-to-back requests to fill the FIFO and wrap the pointers.
        load(2'd0, 4'd9);
        load(2'd1, 4'd6);
        sent = 0; guard = 0; saw_full = 0;
        boh = 8'(1 << $urandom_range(0, 7));
        ba = 2'($urandom_range(0, 3)); bb = 2'($urandom_range(0, 3)); bd = 2'($urandom_range(0, 3));
        while (sent < 8 && guard < 100) begin
            op(boh, ba, bb, bd);
            if (!last_ready_dut) saw_full = 1;
            if (done) dones.push_back(t);
            if (last_acc) begin
                sent++;
                boh = 8'(1 << $urandom_range(0, 7));
                ba = 2'($urandom_range(0, 3)); bb = 2'($urandom_range(0, 3)); bd = 2'($urandom_range(0, 3));
            end
            guard++;
        end
        while (m_busy && guard < 200) begin
            idle();
            if (done) dones.push_back(t);
            guard++;
        end
        check("burst_sent",       32'(sent),          32'(8));
        check("burst_full_seen",  32'(saw_full),      32'(1));
        check("burst_done_count", 32'(dones.size()),  32'(8));
        for (int i = 1; i < dones.size(); i++) begin
            check("burst_done_spacing", 32'(dones[i] - dones[i-1]), 32'(3));
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            sel_k = $urandom_range(0, 9);
            if (sel_k == 0)      roh = 8'd0;
            else if (sel_k == 1) roh = 8'($urandom_range(0, 255));
            else                 roh = 8'(1 << $urandom_range(0, 7));
            tick(($urandom_range(0, 3) != 0), roh,
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 199) == 0));
        end
        drain("drain_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
